fc_input_gather: RTL

Deserialising front end for the fully connected layer. Accepts the previous stage's pixel stream, one pixel per beat over a valid/ready handshake, and assembles one complete flattened frame. It presents that frame as a packed, stable vector to the FC layer's `img_in` until the consumer acknowledges it. It removes the need for upstream stages to hold an entire feature map in parallel.

---
 rtl/fc_pkg.sv | 25 ++
 rtl/fc_frame_bank.sv | 58 +++++
 rtl/fc_input_gather.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the FC input gather front end and the
// FC layer that consumes its frame.
package fc_pkg;

    localparam int DEF_INPUT_SIZE     = 5;
    localparam int DEF_INPUT_CHANNELS = 3;
    localparam int DEF_PX_SIZE        = 8;

    function automatic int flat_size(input int side, input int chans);
        return side * side * chans;
    endfunction

    localparam int DEF_FLAT_SIZE = flat_size(DEF_INPUT_SIZE, DEF_INPUT_CHANNELS);
    localparam int DEF_IDX_W     = $clog2(DEF_FLAT_SIZE);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } gather_state_e;

    // Layout matches fc_layer img_in: [x][y][c][bit]
    typedef logic [DEF_INPUT_SIZE-1:0][DEF_INPUT_SIZE-1:0]
                  [DEF_INPUT_CHANNELS-1:0][DEF_PX_SIZE-1:0] frame_t;

endpackage

// File: rtl/fc_frame_bank.sv
// One frame storage bank: pixel-addressed writes while free, a full flag set
// on frame completion and cleared when the consumer releases the bank.
module fc_frame_bank
    import fc_pkg::*;
#(
    parameter int FLAT_SIZE = DEF_FLAT_SIZE,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int PX_SIZE   = DEF_PX_SIZE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en_i,
    input  logic [IDX_W-1:0]             wr_idx_i,
    input  logic [PX_SIZE-1:0]           wr_px_i,
    input  logic                         fill_done_i,
    input  logic                         release_i,
    output logic                         full_o,
    output logic [FLAT_SIZE*PX_SIZE-1:0] data_o
);

    logic [FLAT_SIZE-1:0][PX_SIZE-1:0] mem_q;
    logic                              full_q;
    logic                              full_d;

    // Full flag next state: completion wins; the two never target one bank together.
    always_comb begin
        full_d = full_q;
        if (fill_done_i) begin
            full_d = 1'b1;
        end else if (release_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Full flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Pixel storage; a full bank is frozen so its contents stay stable for the reader.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (wr_en_i && !full_q) begin
            mem_q[wr_idx_i] <= wr_px_i;
        end
    end

    assign full_o = full_q;
    assign data_o = mem_q;

endmodule

// File: rtl/fc_input_gather.sv
// Pixel-stream to flattened-frame gatherer feeding fc_layer img_in.
// Optional macro FC_GATHER_DBUF_EN selects two ping-pong banks instead of one.
module fc_input_gather
    import fc_pkg::*;
#(
    parameter int INPUT_SIZE     = DEF_INPUT_SIZE,
    parameter int INPUT_CHANNELS = DEF_INPUT_CHANNELS,
    parameter int PX_SIZE        = DEF_PX_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PX_SIZE-1:0]  px_in,
    input  logic                px_valid,
    input  logic                px_last,
    output logic                px_ready,
    output logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] frame_out,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                err_len
);

    localparam int               FLAT_SIZE = flat_size(INPUT_SIZE, INPUT_CHANNELS);
    localparam int               IDX_W     = $clog2(FLAT_SIZE);
    localparam int               FRAME_W   = FLAT_SIZE * PX_SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FLAT_SIZE - 1);

    gather_state_e      state_q;
    gather_state_e      state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic               err_q;
    logic               err_d;

    logic               px_ready_s;
    logic               frame_valid_s;
    logic [FRAME_W-1:0] frame_data_s;
    logic               accept_s;
    logic               at_last_s;
    logic               complete_s;
    logic               early_s;
    logic               release_s;
    logic               next_busy_s;

    assign px_ready_s = (state_q == FILL);
    assign accept_s   = px_valid && px_ready_s;
    assign at_last_s  = (idx_q == LAST_IDX);
    assign complete_s = accept_s && at_last_s;
    assign early_s    = accept_s && px_last && !at_last_s;
    assign release_s  = frame_valid_s && frame_ready;

`ifdef FC_GATHER_DBUF_EN
    logic               fill_q;
    logic               fill_d;
    logic               rd_q;
    logic               rd_d;
    logic [1:0]         full_s;
    logic [FRAME_W-1:0] bank_data_s [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fc_frame_bank #(
            .FLAT_SIZE (FLAT_SIZE),
            .IDX_W     (IDX_W),
            .PX_SIZE   (PX_SIZE)
        ) u_bank (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_en_i     (accept_s && (fill_q == 1'(b))),
            .wr_idx_i    (idx_q),
            .wr_px_i     (px_in),
            .fill_done_i (complete_s && (fill_q == 1'(b))),
            .release_i   (release_s && (rd_q == 1'(b))),
            .full_o      (full_s[b]),
            .data_o      (bank_data_s[b])
        );
    end

    assign frame_valid_s = full_s[rd_q];
    assign frame_data_s  = bank_data_s[rd_q];
    // The bank we move to on completion is busy unless the reader frees it this same edge.
    assign next_busy_s   = full_s[~fill_q] && !(release_s && (rd_q != fill_q));

    // Ping-pong pointer next state.
    always_comb begin
        fill_d = fill_q;
        rd_d   = rd_q;
        if (complete_s) begin
            fill_d = ~fill_q;
        end else begin
            fill_d = fill_q;
        end
        if (release_s) begin
            rd_d = ~rd_q;
        end else begin
            rd_d = rd_q;
        end
    end

    // Ping-pong pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            fill_q <= fill_d;
            rd_q   <= rd_d;
        end
    end
`else
    fc_frame_bank #(
        .FLAT_SIZE (FLAT_SIZE),
        .IDX_W     (IDX_W),
        .PX_SIZE   (PX_SIZE)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (accept_s),
        .wr_idx_i    (idx_q),
        .wr_px_i     (px_in),
        .fill_done_i (complete_s),
        .release_i   (release_s),
        .full_o      (frame_valid_s),
        .data_o      (frame_data_s)
    );

    assign next_busy_s = 1'b1;
`endif

    // Fill-side state: FULL whenever no bank can take the next beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (complete_s && next_busy_s) begin
                    state_d = FULL;
                end else begin
                    state_d = FILL;
                end
            end
            FULL: begin
                if (release_s) begin
                    state_d = FILL;
                end else begin
                    state_d = FULL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Write index and sticky length error; an early px_last discards the partial frame.
    always_comb begin
        idx_d = idx_q;
        err_d = err_q;
        if (complete_s || early_s) begin
            idx_d = '0;
        end else if (accept_s) begin
            idx_d = idx_q + 1'b1;
        end else begin
            idx_d = idx_q;
        end
        if (early_s || (complete_s && !px_last)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign px_ready    = px_ready_s;
    assign frame_valid = frame_valid_s;
    assign frame_out   = frame_data_s;
    assign err_len     = err_q;

endmodule
